ram_arb: RTL and testbench

Two-port arbiter that shares the single data RAM between the core's load/store path (port 0) and a debug/loader master (port 1). It accepts one request per cycle, forwards the winner to the RAM control signals, and returns read data one cycle later on the originating port. Writes complete on the accept cycle. The core stalls its PC while port 0 is valid but not ready.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_arb_if.sv | 28 ++
 rtl/ram_arb_rr_pick2.sv | 26 ++
 rtl/ram_arb.sv | 112 +++++++++++
 tb/tb_ram_arb.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM arbiter: store-width encodings and port identifiers.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_B = 2'd0,
        ST_H = 2'd1,
        ST_W = 2'd2
    } storeops_e;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_e;

    // The grant is one-hot, so bit 1 alone identifies the debug port.
    function automatic port_e winner_of(input logic [1:0] grant);
        return grant[1] ? PORT_DBG : PORT_CORE;
    endfunction

endpackage

// File: rtl/ram_arb_if.sv
// One requester port of the data-RAM arbiter: request handshake plus read response.
interface ram_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import ram_arb_pkg::*;

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [1:0]        storeops;
    logic              lock;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output valid, addr, wdata, we, storeops, lock,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, addr, wdata, we, storeops, lock,
        output ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/ram_arb_rr_pick2.sv
// Two-way round-robin picker with optional grant lock; purely combinational one-hot grant.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  port_e      last_grant,
    input  logic       lock_act,
    input  port_e      lock_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (lock_act) begin
            // A held lock starves the other port even when the owner is idle.
            if (lock_owner == PORT_DBG) grant = {valid1, 1'b0};
            else                        grant = {1'b0, valid0};
        end else if (valid0 && valid1) begin
            grant = (last_grant == PORT_DBG) ? 2'b01 : 2'b10;
        end else begin
            grant = {valid1, valid0};
        end
    end

endmodule

// File: rtl/ram_arb.sv
// Arbiter sharing the data RAM between the core (port 0) and the debug/loader master (port 1).
// Define RAM_ARB_LOCK_EN to let a master hold the grant across transfers for atomic sequences.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              reset,
    ram_arb_if.slave          req0,
    ram_arb_if.slave          req1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [1:0]        ram_storeops,
    input  logic [DATA_W-1:0] ram_rdata
);

    port_e      last_grant;
    logic       rsp_pend;
    port_e      rsp_port;
    logic       lock_act;
    port_e      lock_owner;
    logic [1:0] pick;
    logic [1:0] grant;
    logic       xfer;
    port_e      win;
    logic       win_we;

`ifdef RAM_ARB_LOCK_EN
    logic win_lock;

    assign win_lock = (win == PORT_DBG) ? req1.lock : req0.lock;

    // Every accepted transfer rewrites the lock; only the owner can transfer while it is held.
    always_ff @(posedge CLK) begin
        if (reset) begin
            lock_act   <= 1'b0;
            lock_owner <= PORT_CORE;
        end else if (xfer) begin
            lock_act   <= win_lock;
            lock_owner <= win;
        end
    end
`else
    logic unused_lock;

    assign lock_act    = 1'b0;
    assign lock_owner  = PORT_CORE;
    assign unused_lock = req0.lock ^ req1.lock;
`endif

    rr_pick2 u_pick (
        .valid0     (req0.valid),
        .valid1     (req1.valid),
        .last_grant (last_grant),
        .lock_act   (lock_act),
        .lock_owner (lock_owner),
        .grant      (pick)
    );

    assign grant      = reset ? 2'b00 : pick;
    assign req0.ready = grant[0];
    assign req1.ready = grant[1];
    assign xfer       = |grant;
    assign win        = winner_of(grant);
    assign win_we     = (win == PORT_DBG) ? req1.we : req0.we;

    always_comb begin
        ram_addr     = '0;
        ram_wdata    = '0;
        ram_storeops = 2'b00;
        ram_read     = 1'b0;
        ram_write    = 1'b0;
        if (xfer) begin
            if (win == PORT_DBG) begin
                ram_addr     = req1.addr;
                ram_wdata    = req1.wdata;
                ram_storeops = req1.storeops;
            end else begin
                ram_addr     = req0.addr;
                ram_wdata    = req0.wdata;
                ram_storeops = req0.storeops;
            end
            ram_write = win_we;
            ram_read  = ~win_we;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            last_grant <= PORT_DBG;
            rsp_pend   <= 1'b0;
            rsp_port   <= PORT_CORE;
        end else begin
            rsp_pend <= xfer & ~win_we;
            if (xfer) begin
                last_grant <= win;
                rsp_port   <= win;
            end
        end
    end

    // Reset masks a response already in flight so it never reaches a requester.
    assign req0.rsp_valid = rsp_pend & ~reset & (rsp_port == PORT_CORE);
    assign req1.rsp_valid = rsp_pend & ~reset & (rsp_port == PORT_DBG);
    assign req0.rsp_rdata = req0.rsp_valid ? ram_rdata : '0;
    assign req1.rsp_rdata = req1.rsp_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arb.sv
// Scoreboard bench for ram_arb: expected read responses are queued at accept and popped when due.
module tb_ram_arb;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  so;
        logic        lock;
    } req_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic        CLK;
    logic        reset;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_read;
    logic        ram_write;
    logic [1:0]  ram_storeops;
    logic [31:0] ram_rdata;

    int   assert_count = 0;
    int   fail_count   = 0;
    int   cyc          = 0;
    logic m_last       = 1'b1;
    logic m_lock_act   = 1'b0;
    logic m_lock_owner = 1'b0;
    rsp_t sb_q[$];

    ram_arb_if #(.ADDR_W(32), .DATA_W(32)) req0_bus ();
    ram_arb_if #(.ADDR_W(32), .DATA_W(32)) req1_bus ();

    ram_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .req0         (req0_bus.slave),
        .req1         (req1_bus.slave),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_read     (ram_read),
        .ram_write    (ram_write),
        .ram_storeops (ram_storeops),
        .ram_rdata    (ram_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] ramVal(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Behavioural RAM: read data appears the cycle after the read strobe.
    always @(posedge CLK) ram_rdata <= ram_read ? ramVal(ram_addr) : 32'hBAD0_BAD0;

    function automatic req_t mk(input logic v, input logic [31:0] a, input logic [31:0] d,
                                input logic we, input logic [1:0] so, input logic lk);
        req_t r;
        r.valid = v; r.addr = a; r.wdata = d; r.we = we; r.so = so; r.lock = lk;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One bus cycle: drive, predict, check at the falling edge, then advance the reference model.
    task automatic applyStimulus(input req_t r0, input req_t r1, input logic rst,
                                 output logic [1:0] obs_grant, output logic [32:0] obs_rsp0);
        logic [1:0] eg;
        req_t       w;
        rsp_t       e;
        req0_bus.valid = r0.valid; req0_bus.addr = r0.addr; req0_bus.wdata = r0.wdata;
        req0_bus.we = r0.we; req0_bus.storeops = r0.so; req0_bus.lock = r0.lock;
        req1_bus.valid = r1.valid; req1_bus.addr = r1.addr; req1_bus.wdata = r1.wdata;
        req1_bus.we = r1.we; req1_bus.storeops = r1.so; req1_bus.lock = r1.lock;
        reset = rst;
        if (rst)                      eg = 2'b00;
        else if (m_lock_act)          eg = m_lock_owner ? {r1.valid, 1'b0} : {1'b0, r0.valid};
        else if (r0.valid && r1.valid) eg = m_last ? 2'b01 : 2'b10;
        else                          eg = {r1.valid, r0.valid};
        w = eg[1] ? r1 : r0;
        if (rst) sb_q.delete();
        @(negedge CLK);
        checkOutput("ready0", 64'(req0_bus.ready), 64'(eg[0]));
        checkOutput("ready1", 64'(req1_bus.ready), 64'(eg[1]));
        checkOutput("ram_read", 64'(ram_read), 64'((|eg) & ~w.we));
        checkOutput("ram_write", 64'(ram_write), 64'((|eg) & w.we));
        if (|eg) begin
            checkOutput("ram_addr", 64'(ram_addr), 64'(w.addr));
            if (w.we) begin
                checkOutput("ram_wdata", 64'(ram_wdata), 64'(w.wdata));
                checkOutput("ram_storeops", 64'(ram_storeops), 64'(w.so));
            end
        end
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            if (e.port) begin
                checkOutput("rsp1_valid", 64'(req1_bus.rsp_valid), 64'(1));
                checkOutput("rsp1_rdata", 64'(req1_bus.rsp_rdata), 64'(e.data));
                checkOutput("rsp0_idle", 64'(req0_bus.rsp_valid), 64'(0));
            end else begin
                checkOutput("rsp0_valid", 64'(req0_bus.rsp_valid), 64'(1));
                checkOutput("rsp0_rdata", 64'(req0_bus.rsp_rdata), 64'(e.data));
                checkOutput("rsp1_idle", 64'(req1_bus.rsp_valid), 64'(0));
            end
        end else begin
            checkOutput("rsp_none", 64'({req1_bus.rsp_valid, req0_bus.rsp_valid}), 64'(0));
        end
        obs_grant = {req1_bus.ready, req0_bus.ready};
        obs_rsp0  = {req0_bus.rsp_valid, req0_bus.rsp_rdata};
        @(posedge CLK);
        #1;
        if (rst) begin
            m_last = 1'b1; m_lock_act = 1'b0; m_lock_owner = 1'b0;
        end else if (|eg) begin
            m_last = eg[1];
`ifdef RAM_ARB_LOCK_EN
            m_lock_act   = w.lock;
            m_lock_owner = eg[1];
`endif
            if (!w.we) begin
                e.port = eg[1]; e.data = ramVal(w.addr); e.due = cyc + 1;
                sb_q.push_back(e);
            end
        end
        cyc++;
    endtask

    initial begin
        req_t        idle, c0, c1;
        logic [1:0]  g;
        logic [32:0] r;
        logic [1:0]  alt_exp [4];
        idle = mk(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01; alt_exp[3] = 2'b10;
        reset = 1'b1;
        req0_bus.valid = 1'b0; req0_bus.addr = '0; req0_bus.wdata = '0;
        req0_bus.we = 1'b0; req0_bus.storeops = 2'd0; req0_bus.lock = 1'b0;
        req1_bus.valid = 1'b0; req1_bus.addr = '0; req1_bus.wdata = '0;
        req1_bus.we = 1'b0; req1_bus.storeops = 2'd0; req1_bus.lock = 1'b0;
        @(posedge CLK);
        #1;

        // Reset with both ports requesting, then port 0 wins the first tie.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(mk(1, 32'h10, 0, 0, 2'd2, 0), mk(1, 32'h44, 0, 0, 2'd2, 0), 1'b1, g, r);
            checkOutput("reset_grant", 64'(g), 64'(0));
        end
        applyStimulus(mk(1, 32'h10, 0, 0, 2'd2, 0), mk(1, 32'h44, 0, 0, 2'd2, 0), 1'b0, g, r);
        checkOutput("first_grant", 64'(g), 64'(2'b01));
        applyStimulus(idle, idle, 1'b0, g, r);
        checkOutput("first_rsp", 64'(r), 64'({1'b1, 32'hDEAD_BEEF}));

        // Port 1 alone, then four contended cycles alternating 0,1,0,1.
        applyStimulus(idle, mk(1, 32'h44, 0, 0, 2'd2, 0), 1'b0, g, r);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mk(1, 32'h18, 0, 0, 2'd2, 0), mk(1, 32'h20, 32'h1234_5678, 1, 2'd2, 0),
                          1'b0, g, r);
            checkOutput("alt_grant", 64'(g), 64'(alt_exp[i]));
        end

        // Byte write then read of the same address on consecutive cycles.
        applyStimulus(idle, mk(1, 32'h30, 32'h0000_00AB, 1, 2'd0, 0), 1'b0, g, r);
        applyStimulus(mk(1, 32'h30, 0, 0, 2'd2, 0), idle, 1'b0, g, r);
        applyStimulus(idle, idle, 1'b0, g, r);
        checkOutput("byte_rsp", 64'(r), 64'({1'b1, ramVal(32'h30)}));

        // Back-to-back reads at full throughput.
        for (int i = 0; i < 3; i++)
            applyStimulus(mk(1, 32'h100 + 32'(4 * i), 0, 0, 2'd2, 0), idle, 1'b0, g, r);
        applyStimulus(idle, idle, 1'b0, g, r);

        applyStimulus(idle, mk(1, 32'h40, 0, 0, 2'd2, 1), 1'b0, g, r);
        checkOutput("lock_take", 64'(g), 64'(2'b10));
`ifdef RAM_ARB_LOCK_EN
        for (int i = 0; i < 2; i++) begin
            applyStimulus(mk(1, 32'h60, 0, 0, 2'd2, 0), idle, 1'b0, g, r);
            checkOutput("lock_block", 64'(g), 64'(0));
        end
        applyStimulus(mk(1, 32'h60, 0, 0, 2'd2, 0), mk(1, 32'h40, 32'h55, 1, 2'd2, 0), 1'b0, g, r);
        checkOutput("lock_owner_wr", 64'(g), 64'(2'b10));
        applyStimulus(mk(1, 32'h60, 0, 0, 2'd2, 0), idle, 1'b0, g, r);
        checkOutput("lock_release", 64'(g), 64'(2'b01));
`else
        applyStimulus(mk(1, 32'h60, 0, 0, 2'd2, 0), idle, 1'b0, g, r);
        checkOutput("lock_ignored", 64'(g), 64'(2'b01));
`endif

        // Reset right after a read accept drops the pending response.
        applyStimulus(mk(1, 32'h50, 0, 0, 2'd2, 0), idle, 1'b0, g, r);
        applyStimulus(mk(1, 32'h54, 0, 0, 2'd2, 0), idle, 1'b1, g, r);
        checkOutput("reset_drop", 64'(r[32]), 64'(0));
        applyStimulus(mk(1, 32'h54, 0, 0, 2'd2, 0), idle, 1'b0, g, r);
        checkOutput("post_reset_grant", 64'(g), 64'(2'b01));
        applyStimulus(idle, idle, 1'b0, g, r);
        checkOutput("post_reset_rsp", 64'(r), 64'({1'b1, ramVal(32'h54)}));

        // Random traffic; a requester keeps its request until it is accepted.
        c0 = idle; c1 = idle;
        for (int i = 0; i < 60; i++) begin
            if (!c0.valid || g[0])
                c0 = mk(1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                        $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'b0);
            if (!c1.valid || g[1])
                c1 = mk(1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                        $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'b0);
            applyStimulus(c0, c1, 1'b0, g, r);
        end
        applyStimulus(idle, idle, 1'b0, g, r);
        checkOutput("drain", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
